relu_maxpool: RTL and testbench

Streaming 2×2 / stride-2 max-pooling unit that sits directly behind the ReLU stage of the CNN datapath. It consumes ReLU outputs of one feature-map channel in raster order over a valid/ready input stream. It emits one pooled value per 2×2 window over a valid/ready output stream. A half-width line buffer holds the horizontal maxima of each even row until the matching odd row arrives.

---
 rtl/relu_maxpool_pkg.sv | 21 ++
 rtl/pool_line_buffer.sv | 37 +++
 rtl/relu_maxpool.sv | 154 +++++++++++++++
 tb/tb_relu_maxpool.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/relu_maxpool_pkg.sv
// -----------------------------------------------------------------------------
// relu_maxpool_pkg
// Shared constants and the FSM state type for the 2x2 / stride-2 max-pooling
// unit that follows the ReLU stage.
//   INTERNAL_BITS : datapath sample width (signed two's complement)
//   POOL_MAX_COLS : widest supported input row (must be even)
//   pool_state_e  : IDLE -> RUN -> DRAIN -> DONE -> IDLE
// -----------------------------------------------------------------------------
package relu_maxpool_pkg;

    localparam int INTERNAL_BITS = 32;
    localparam int POOL_MAX_COLS = 64;

    typedef enum logic [1:0] {
        POOL_IDLE  = 2'd0,
        POOL_RUN   = 2'd1,
        POOL_DRAIN = 2'd2,
        POOL_DONE  = 2'd3
    } pool_state_e;

endpackage

// File: rtl/pool_line_buffer.sv
// -----------------------------------------------------------------------------
// pool_line_buffer
// Half-width line buffer holding the horizontal maxima of the current even
// row until the matching odd row arrives. One shared address: the same slot
// is written on an even row and read back on the following odd row.
// Ports:
//   clk      : clock, write on rising edge
//   wr_en    : write enable
//   addr     : slot index (column pair)
//   wr_data  : value to store
//   rd_data  : combinational read of slot addr
// -----------------------------------------------------------------------------
module pool_line_buffer #(
    parameter int DEPTH  = 32,
    parameter int DATA_W = 32,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: storage arrays carry no reset; every slot is written on an even
    // row before the odd row reads it, so a reset would only cost flops.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

    assign rd_data = mem[addr];

endmodule

// File: rtl/relu_maxpool.sv
// -----------------------------------------------------------------------------
// relu_maxpool
// Streaming 2x2 / stride-2 max pooling of one feature-map channel. Pixels
// arrive in raster order on a valid/ready stream; one pooled value per 2x2
// window leaves on a single-entry valid/ready output stage.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   start                : frame start pulse (honoured only when idle)
//   cfg_cols, cfg_rows   : frame size, sampled on an accepted start
//   in_valid/in_ready    : input handshake, in_data = ReLU sample
//   out_valid/out_ready  : output handshake, out_data = pooled sample
//   busy                 : frame in progress (state is not IDLE)
//   done                 : one-cycle pulse after the last output is taken
// -----------------------------------------------------------------------------
module relu_maxpool
    import relu_maxpool_pkg::*;
#(
    parameter int MAX_COLS = POOL_MAX_COLS,
    parameter int DATA_W   = INTERNAL_BITS,
    parameter int DIM_W    = $clog2(MAX_COLS) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DIM_W-1:0]  cfg_cols,
    input  logic [DIM_W-1:0]  cfg_rows,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done
);

    localparam int LB_DEPTH = MAX_COLS / 2;
    localparam int ADDR_W   = $clog2(LB_DEPTH);

    function automatic logic [DATA_W-1:0] smax(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
        return ($signed(a) > $signed(b)) ? a : b;
    endfunction

    pool_state_e       state_q, state_d;
    logic [DIM_W-1:0]  cols_q, rows_q;
    logic [DIM_W-1:0]  col_cnt, row_cnt;
    logic [DATA_W-1:0] h_reg;

    // Configuration as it would be latched: LSB forced to 0, width clamped.
    logic [DIM_W-1:0]  cols_even, cols_cfg, rows_cfg;
    assign cols_even = cfg_cols & ~DIM_W'(1);
    assign cols_cfg  = (cols_even > DIM_W'(MAX_COLS)) ? DIM_W'(MAX_COLS) : cols_even;
    assign rows_cfg  = cfg_rows & ~DIM_W'(1);

    logic start_fire, zero_size, in_fire, out_fire, col_last, row_last;
    assign start_fire = start && (state_q == POOL_IDLE);
    assign zero_size  = (cols_cfg == '0) || (rows_cfg == '0);
    assign in_fire    = in_valid && in_ready;
    assign out_fire   = out_valid && out_ready;
    assign col_last   = (col_cnt == cols_q - DIM_W'(1));
    assign row_last   = (row_cnt == rows_q - DIM_W'(1));

    assign in_ready = (state_q == POOL_RUN) && !out_valid;
    assign busy     = (state_q != POOL_IDLE);
    assign done     = (state_q == POOL_DONE);

    // Max logic: horizontal pair, then fold in the even-row pair from the buffer.
    logic [DATA_W-1:0] pair_max, lb_rd, pool_max;
    logic              lb_we, win_last;
    assign pair_max = smax(h_reg, in_data);
    assign pool_max = smax(pair_max, lb_rd);
    assign lb_we    = in_fire && !row_cnt[0] && col_cnt[0];
    assign win_last = in_fire &&  row_cnt[0] && col_cnt[0];

    pool_line_buffer #(
        .DEPTH  (LB_DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_line_buffer (
        .clk     (clk),
        .wr_en   (lb_we),
        .addr    (col_cnt[ADDR_W:1]),
        .wr_data (pair_max),
        .rd_data (lb_rd)
    );

    always_comb begin
        // NOTE: default assignment first so no path leaves state_d unassigned
        // (which would infer a latch).
        state_d = state_q;
        case (state_q)
            POOL_IDLE:  if (start)    state_d = zero_size ? POOL_DONE : POOL_RUN;
            POOL_RUN:   if (in_fire && col_last && row_last) state_d = POOL_DRAIN;
            POOL_DRAIN: if (out_fire) state_d = POOL_DONE;
            POOL_DONE:                state_d = POOL_IDLE;
            default:                  state_d = POOL_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= POOL_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cols_q  <= '0;
            rows_q  <= '0;
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (start_fire) begin
            cols_q  <= cols_cfg;
            rows_q  <= rows_cfg;
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (in_fire) begin
            if (col_last) begin
                col_cnt <= '0;
                row_cnt <= row_cnt + DIM_W'(1);
            end else begin
                col_cnt <= col_cnt + DIM_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_reg <= '0;
        end else if (in_fire && !col_cnt[0]) begin
            h_reg <= in_data;
        end
    end

    // Single-entry output stage; in_ready is low while it is full, so a load
    // and an unload never coincide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (win_last) begin
            out_valid <= 1'b1;
            out_data  <= pool_max;
        end else if (out_fire) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_relu_maxpool.sv
// -----------------------------------------------------------------------------
// tb_relu_maxpool
// Directed frames against a window-max model of the pooling unit. A negedge
// compare process checks every output handshake, output stability under
// back-pressure and the done pulse; hand-computed literals pin the model.
// -----------------------------------------------------------------------------
module tb_relu_maxpool;

    localparam int DATA_W   = 32;
    localparam int MAX_COLS = 64;
    localparam int DIM_W    = 7;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [DIM_W-1:0]  cfg_cols = '0;
    logic [DIM_W-1:0]  cfg_rows = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [DATA_W-1:0] out_data;
    logic              busy;
    logic              done;

    int checks = 0;
    int errors = 0;

    logic signed [DATA_W-1:0] pix[$];
    logic signed [DATA_W-1:0] exp_q[$];

    int                ready_mode = 0;  // 0: always ready, 1: ready 1-of-3, 2: never
    int                done_cnt   = 0;
    bit                zero_frame = 1'b0;
    bit                hs_prev    = 1'b0;
    bit                stall_prev = 1'b0;
    bit                done_prev  = 1'b0;
    logic [DATA_W-1:0] held       = '0;

    always #5 clk = ~clk;

    relu_maxpool dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .cfg_cols  (cfg_cols),
        .cfg_rows  (cfg_rows),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done)
    );

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, $signed(act), $signed(expv));
        end
    endtask

    // Model: each output is the signed maximum of its four window pixels.
    function automatic void model_push(input int cols, input int rows);
        for (int r = 0; r < rows / 2; r++) begin
            for (int c = 0; c < cols / 2; c++) begin
                logic signed [DATA_W-1:0] m;
                m = pix[2*r*cols + 2*c];
                if (pix[2*r*cols + 2*c + 1]     > m) m = pix[2*r*cols + 2*c + 1];
                if (pix[(2*r+1)*cols + 2*c]     > m) m = pix[(2*r+1)*cols + 2*c];
                if (pix[(2*r+1)*cols + 2*c + 1] > m) m = pix[(2*r+1)*cols + 2*c + 1];
                exp_q.push_back(m);
            end
        end
    endfunction

    function automatic int eff_cols(input int c);
        int e;
        e = c & ~1;
        return (e > MAX_COLS) ? MAX_COLS : e;
    endfunction

    // out_ready pattern, driven just after each rising edge.
    initial begin
        int rc;
        rc = 0;
        forever begin
            @(posedge clk);
            #1;
            rc++;
            case (ready_mode)
                1:       out_ready = (rc % 3 == 0);
                2:       out_ready = 1'b0;
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Compare process: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            hs_prev    = 1'b0;
            stall_prev = 1'b0;
            done_prev  = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_valid", DATA_W'(out_valid), 1);
                check("stall_data", out_data, held);
            end
            if (done) begin
                done_cnt++;
                if (!zero_frame) check("done_after_handshake", DATA_W'(hs_prev), 1);
            end
            if (done_prev) begin
                check("done_width", DATA_W'(done), 0);
                check("busy_after_done", DATA_W'(busy), 0);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %0d, expected no output", $signed(out_data));
                end else begin
                    check("out_data", out_data, exp_q.pop_front());
                end
            end
            hs_prev    = out_valid && out_ready;
            stall_prev = out_valid && !out_ready;
            held       = out_data;
            done_prev  = done;
        end
    end

    // Runs one frame. n_feed < frame size leaves it partial (no done wait).
    task automatic run_frame(input int cfg_c, input int cfg_r, input int n_feed,
                             input bit gaps, input bit start_mid);
        int  total;
        int  idx;
        int  cyc;
        int  d0;
        bit  fired;
        total      = eff_cols(cfg_c) * (cfg_r & ~1);
        zero_frame = (total == 0);
        d0         = done_cnt;
        idx        = 0;
        cyc        = 0;
        @(posedge clk); #1;
        start    = 1'b1;
        cfg_cols = DIM_W'(cfg_c);
        cfg_rows = DIM_W'(cfg_r);
        in_valid = zero_frame;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("busy_rise", DATA_W'(busy), 1);
        if (zero_frame) begin
            check("zero_done", DATA_W'(done), 1);
            check("zero_in_ready", DATA_W'(in_ready), 0);
            @(negedge clk);
            check("zero_done_clear", DATA_W'(done), 0);
            check("zero_idle", DATA_W'(busy), 0);
            check("zero_in_ready_idle", DATA_W'(in_ready), 0);
            in_valid = 1'b0;
        end
        @(posedge clk); #1;
        while (idx < n_feed && cyc < 40 * n_feed + 100) begin
            in_valid = gaps ? ($urandom_range(2, 0) != 0) : 1'b1;
            in_data  = pix[idx];
            if (start_mid && idx == 3) begin
                start    = 1'b1;
                cfg_cols = DIM_W'(2);
                cfg_rows = DIM_W'(2);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            fired = in_valid && in_ready;
            @(posedge clk); #1;
            if (fired) idx++;
            cyc++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        if (idx < n_feed) begin
            checks++;
            errors++;
            $display("FAIL feed_timeout: accepted %0d, required %0d", idx, n_feed);
        end
        if (n_feed == total) begin
            cyc = 0;
            while (done_cnt == d0 && cyc < 300) begin
                @(negedge clk);
                cyc++;
            end
            repeat (3) @(negedge clk);
            check("done_pulses", DATA_W'(done_cnt - d0), 1);
            check("outputs_left", DATA_W'(exp_q.size()), 0);
        end
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        // Reset values.
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", DATA_W'(in_ready), 0);
        check("rst_out_valid", DATA_W'(out_valid), 0);
        check("rst_busy", DATA_W'(busy), 0);
        check("rst_done", DATA_W'(done), 0);
        check("rst_out_data", out_data, 0);
        rst_n = 1'b1;

        // 4x4 raster 0..15, continuous.
        pix.delete();
        for (int i = 0; i < 16; i++) pix.push_back(DATA_W'(i));
        model_push(4, 4);
        check("model_4x4_0", exp_q[0], 5);
        check("model_4x4_1", exp_q[1], 7);
        check("model_4x4_2", exp_q[2], 13);
        check("model_4x4_3", exp_q[3], 15);
        run_frame(4, 4, 16, 1'b0, 1'b0);

        // Same frame, input gaps, ready 1-of-3, stray start while busy.
        ready_mode = 1;
        model_push(4, 4);
        run_frame(4, 4, 16, 1'b1, 1'b1);
        ready_mode = 0;

        // Signed compare.
        pix.delete();
        pix.push_back(-5); pix.push_back(3); pix.push_back(-1); pix.push_back(-7);
        model_push(2, 2);
        check("model_signed", exp_q[0], 3);
        run_frame(2, 2, 4, 1'b0, 1'b0);

        // Zero-size frames (cols 0, rows 0, both odd-1 forced to 0).
        run_frame(0, 4, 0, 1'b0, 1'b0);
        run_frame(4, 0, 0, 1'b0, 1'b0);
        run_frame(1, 1, 0, 1'b0, 1'b0);

        // 64x2 ramp, configured wider than MAX_COLS so it clamps to 64.
        pix.delete();
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 64; c++) pix.push_back(DATA_W'(r * 64 + c));
        model_push(64, 2);
        check("model_ramp_first", exp_q[0], 65);
        check("model_ramp_last", exp_q[31], 127);
        run_frame(100, 2, 128, 1'b0, 1'b0);

        // Reset mid-way through row 1 with a completed window held unaccepted.
        pix.delete();
        for (int i = 0; i < 16; i++) pix.push_back(DATA_W'(i));
        ready_mode = 2;
        run_frame(4, 4, 6, 1'b0, 1'b0);
        @(negedge clk);
        check("pre_reset_valid", DATA_W'(out_valid), 1);
        d0 = done_cnt;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", DATA_W'(out_valid), 0);
        check("mid_rst_out_data", out_data, 0);
        check("mid_rst_busy", DATA_W'(busy), 0);
        check("mid_rst_in_ready", DATA_W'(in_ready), 0);
        check("mid_rst_done", DATA_W'(done), 0);
        ready_mode = 0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("no_done_after_reset", DATA_W'(done_cnt - d0), 0);

        // Clean 4x4 frame after reset, configured 5x5 (LSBs forced to 0).
        model_push(4, 4);
        run_frame(5, 5, 16, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
